// File: rtl/ps2_key_event_decoder_if.sv
// Key event link: scan bytes arrive from the PS/2 receiver; decoded key events
// leave toward the ASCII converter / host mailbox under valid/ready.
interface ps2_key_event_decoder_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic [4:0] ev_mods;
    logic       ev_upper;

    modport master (
        input  rx_valid, rx_data, ev_ready,
        output ev_valid, ev_code, ev_ext, ev_break, ev_mods, ev_upper
    );

    modport slave (
        output rx_valid, rx_data, ev_ready,
        input  ev_valid, ev_code, ev_ext, ev_break, ev_mods, ev_upper
    );
endinterface

// File: rtl/ps2_key_event_decoder.sv
// Set-2 scan decoder with modifier tracking, repeat filter and an event FIFO.
// Event visible two edges after its final byte; a full FIFO without a pop drops the event (sticky overflow).
module ps2_key_event_decoder #(
    parameter int FIFO_DEPTH    = 8,
    parameter int FILTER_REPEAT = 1,
    parameter int TIMEOUT       = 500000
) (
    input  logic                          clk,
    input  logic                          reset,
    ps2_key_event_decoder_if.master       bus,
    output logic                          caps_led,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [4:0] mods;
        logic       upper;
    } event_t;

    state_t        state, state_next, state_eff;
    logic [2:0]    skip_cnt, skip_next;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;

    logic          key_fire, key_ext, key_brk, key_pause, bat_clear;
    logic [7:0]    key_code;
    logic [7:0]    key_idx;
    logic          key_take;

    logic [255:0]  keydown;
    logic          shift_l, shift_r, ctrl, alt, caps_lock;
    logic          shift_l_n, shift_r_n, ctrl_n, alt_n, caps_n;

    // A byte arriving on the timeout cycle is decoded as if already back in IDLE.
    assign tmo_hit   = (state != IDLE) && (tmo_cnt >= TMO_LAST);
    assign state_eff = tmo_hit ? IDLE : state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            skip_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            state    <= state_next;
            skip_cnt <= skip_next;
            if (bus.rx_valid || state_next == IDLE)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = tmo_hit ? IDLE : state;
        skip_next  = skip_cnt;
        key_fire   = 1'b0;
        key_code   = bus.rx_data;
        key_ext    = 1'b0;
        key_brk    = 1'b0;
        key_pause  = 1'b0;
        bat_clear  = 1'b0;
        if (bus.rx_valid) begin
            case (state_eff)
                IDLE: begin
                    case (bus.rx_data)
                        8'hE0: state_next = EXT;
                        8'hF0: state_next = BRK;
                        8'hE1: begin
                            state_next = PAUSE;
                            skip_next  = 3'd7;
                        end
                        8'hAA: bat_clear = 1'b1;
                        8'hFA, 8'hFE, 8'h00, 8'hFF: key_fire = 1'b0;
                        default: key_fire = 1'b1;
                    endcase
                end
                EXT: begin
                    state_next = IDLE;
                    if (bus.rx_data == 8'hF0) begin
                        state_next = EXT_BRK;
                    end else if (bus.rx_data != 8'h12 && bus.rx_data != 8'h59) begin
                        key_fire = 1'b1;
                        key_ext  = 1'b1;
                    end
                end
                BRK: begin
                    state_next = IDLE;
                    key_fire   = 1'b1;
                    key_brk    = 1'b1;
                end
                EXT_BRK: begin
                    state_next = IDLE;
                    key_fire   = 1'b1;
                    key_ext    = 1'b1;
                    key_brk    = 1'b1;
                end
                PAUSE: begin
                    skip_next = skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) begin
                        state_next = IDLE;
                        key_fire   = 1'b1;
                        key_ext    = 1'b1;
                        key_pause  = 1'b1;
                        key_code   = 8'h77;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Pause never sends a release, so it bypasses the held-key bitmap entirely.
    assign key_idx  = (key_code == 8'h83) ? {key_ext, 7'h02} : {key_ext, key_code[6:0]};
    assign key_take = key_fire &&
                      !((FILTER_REPEAT != 0) && !key_brk && !key_pause && keydown[key_idx]);

    always_comb begin
        shift_l_n = shift_l;
        shift_r_n = shift_r;
        ctrl_n    = ctrl;
        alt_n     = alt;
        caps_n    = caps_lock;
        if (key_take && !key_pause) begin
            if (!key_ext && key_code == 8'h12) shift_l_n = !key_brk;
            if (!key_ext && key_code == 8'h59) shift_r_n = !key_brk;
            if (key_code == 8'h14)             ctrl_n    = !key_brk;
            if (key_code == 8'h11)             alt_n     = !key_brk;
            if (!key_ext && key_code == 8'h58 && !key_brk) caps_n = !caps_lock;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            keydown   <= '0;
            shift_l   <= 1'b0;
            shift_r   <= 1'b0;
            ctrl      <= 1'b0;
            alt       <= 1'b0;
            caps_lock <= 1'b0;
        end else if (bat_clear) begin
            keydown <= '0;
            shift_l <= 1'b0;
            shift_r <= 1'b0;
            ctrl    <= 1'b0;
            alt     <= 1'b0;
        end else begin
            if (key_take && !key_pause)
                keydown[key_idx] <= !key_brk;
            shift_l   <= shift_l_n;
            shift_r   <= shift_r_n;
            ctrl      <= ctrl_n;
            alt       <= alt_n;
            caps_lock <= caps_n;
        end
    end

    assign caps_led = caps_lock;

    event_t          push_ev, head;
    event_t          mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr, rd_ptr_next;
    logic            head_vld, pop, full, push_ok;

    always_comb begin
        push_ev.code  = key_code;
        push_ev.ext   = key_ext;
        push_ev.brk   = key_brk;
        push_ev.mods  = {caps_n, alt_n, ctrl_n, shift_r_n, shift_l_n};
        push_ev.upper = (shift_l_n | shift_r_n) ^ caps_n;
    end

    assign fifo_level  = wr_ptr - rd_ptr;
    assign full        = (fifo_level == FULL_LVL);
    assign pop         = head_vld && bus.ev_ready;
    assign push_ok     = key_take && (!full || pop);
    assign rd_ptr_next = rd_ptr + {{AW{1'b0}}, pop};

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr[AW-1:0]] <= push_ev;
    end

    // Head register looks at the pre-push write pointer, giving the extra edge of latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            head_vld <= 1'b0;
            head     <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (key_take && !push_ok)
                overflow <= 1'b1;
            rd_ptr   <= rd_ptr_next;
            head_vld <= (wr_ptr != rd_ptr_next);
            if (wr_ptr != rd_ptr_next)
                head <= mem[rd_ptr_next[AW-1:0]];
        end
    end

    assign bus.ev_valid = head_vld;
    assign bus.ev_code  = head.code;
    assign bus.ev_ext   = head.ext;
    assign bus.ev_break = head.brk;
    assign bus.ev_mods  = head.mods;
    assign bus.ev_upper = head.upper;
endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Scoreboard bench for the key event decoder; a second instance with repeat
// filtering disabled shares the byte stream during the repeat test.
module tb_ps2_key_event_decoder;
    localparam int TMO = 20;

    logic clk, reset, en2;
    logic caps_led, overflow, caps_led2, overflow2;
    logic [2:0] fifo_level;
    logic [3:0] fifo_level2;
    int n_cmp, n_err, n_ev2;
    logic [15:0] sb [$];

    ps2_key_event_decoder_if bus ();
    ps2_key_event_decoder_if bus2 ();

    ps2_key_event_decoder #(.FIFO_DEPTH(4), .FILTER_REPEAT(1), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .caps_led(caps_led), .overflow(overflow), .fifo_level(fifo_level)
    );

    ps2_key_event_decoder #(.FIFO_DEPTH(8), .FILTER_REPEAT(0), .TIMEOUT(TMO)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2),
        .caps_led(caps_led2), .overflow(overflow2), .fifo_level(fifo_level2)
    );

    assign bus2.rx_valid = bus.rx_valid & en2;
    assign bus2.rx_data  = bus.rx_data;
    assign bus2.ev_ready = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Event word is {code, ext, brk, mods, upper}; upper derived from the mods snapshot.
    task automatic expect_ev(input logic [7:0] code, input logic ext, input logic brk,
                             input logic [4:0] mods);
        sb.push_back({code, ext, brk, mods, (mods[0] | mods[1]) ^ mods[4]});
    endtask

    always @(negedge clk) begin
        logic [15:0] got, exp;
        if (!reset && bus.ev_valid && bus.ev_ready) begin
            got = {bus.ev_code, bus.ev_ext, bus.ev_break, bus.ev_mods, bus.ev_upper};
            if (sb.size() == 0) begin
                check("ev_spurious", {16'h0, got}, 32'hFFFF_FFFF);
            end else begin
                exp = sb.pop_front();
                check("ev", {16'h0, got}, {16'h0, exp});
            end
        end
        if (!reset && bus2.ev_valid)
            n_ev2++;
    end

    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (4) begin @(posedge clk); #1; end
        check(tag, sb.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        sb.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_err = 0; n_ev2 = 0;
        reset = 1'b1; en2 = 1'b0;
        bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.ev_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("rst_ev_valid", bus.ev_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_caps", caps_led, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single make, with first-event latency
        expect_ev(8'h1C, 0, 0, 5'b00000);
        bus.rx_data = 8'h1C; bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        check("lat_edge_k", bus.ev_valid, 0);
        @(posedge clk); #1;
        check("lat_edge_k1", bus.ev_valid, 1);
        drain("drain_single");
        check("level_empty", fifo_level, 0);

        // Shift modifier
        do_reset();
        expect_ev(8'h12, 0, 0, 5'b00001);
        expect_ev(8'h1C, 0, 0, 5'b00001);
        expect_ev(8'h1C, 0, 1, 5'b00001);
        expect_ev(8'h12, 0, 1, 5'b00000);
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
        drain("drain_shift");

        // Typematic repeat filter vs. unfiltered twin
        do_reset();
        n_ev2 = 0;
        en2 = 1'b1;
        expect_ev(8'h1C, 0, 0, 5'b00000);
        expect_ev(8'h1C, 0, 1, 5'b00000);
        for (int i = 0; i < 5; i++) send(8'h1C);
        send(8'hF0); send(8'h1C);
        en2 = 1'b0;
        drain("drain_filter");
        check("norep_count", n_ev2, 6);
        check("norep_overflow", overflow2, 0);
        check("norep_level", fifo_level2, 0);

        // Caps lock toggle
        do_reset();
        expect_ev(8'h58, 0, 0, 5'b10000);
        expect_ev(8'h58, 0, 1, 5'b10000);
        expect_ev(8'h12, 0, 0, 5'b10001);
        expect_ev(8'h1C, 0, 0, 5'b10001);
        send(8'h58); send(8'hF0); send(8'h58); send(8'h12); send(8'h1C);
        drain("drain_caps_on");
        check("caps_on", caps_led, 1);
        check("caps_mirror_twin", caps_led2, 0);
        expect_ev(8'h1C, 0, 1, 5'b10001);
        expect_ev(8'h12, 0, 1, 5'b10000);
        expect_ev(8'h58, 0, 0, 5'b00000);
        expect_ev(8'h58, 0, 1, 5'b00000);
        send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
        send(8'h58); send(8'hF0); send(8'h58);
        drain("drain_caps_off");
        check("caps_off", caps_led, 0);

        // Fake shift then extended make; pause sequence
        do_reset();
        expect_ev(8'h75, 1, 0, 5'b00000);
        send(8'hE0); send(8'h12); send(8'hE0); send(8'h75);
        expect_ev(8'h77, 1, 0, 5'b00000);
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        drain("drain_ext_pause");

        // Timeout abandons E0; short gap keeps it
        do_reset();
        expect_ev(8'h1C, 0, 0, 5'b00000);
        send(8'hE0);
        repeat (TMO + 1) begin @(posedge clk); #1; end
        send(8'h1C);
        expect_ev(8'h1C, 1, 0, 5'b00000);
        send(8'hE0);
        repeat (5) begin @(posedge clk); #1; end
        send(8'h1C);
        drain("drain_timeout");

        // BAT clears held keys/modifiers; F7 aliases index 02; ack bytes ignored
        do_reset();
        expect_ev(8'h12, 0, 0, 5'b00001);
        expect_ev(8'h1C, 0, 0, 5'b00000);
        expect_ev(8'h12, 0, 0, 5'b00001);
        expect_ev(8'h83, 0, 0, 5'b00001);
        send(8'h12); send(8'hAA); send(8'h1C); send(8'h12);
        send(8'h83); send(8'h02); send(8'hFA); send(8'hFE);
        drain("drain_bat_f7");

        // Overflow with depth 4
        do_reset();
        bus.ev_ready = 1'b0;
        expect_ev(8'h15, 0, 0, 5'b00000);
        expect_ev(8'h1D, 0, 0, 5'b00000);
        expect_ev(8'h24, 0, 0, 5'b00000);
        expect_ev(8'h2D, 0, 0, 5'b00000);
        send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C); send(8'h35);
        check("ovf_level", fifo_level, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_head_code", bus.ev_code, 8'h15);
        bus.ev_ready = 1'b1;
        drain("drain_overflow");

        // Push accepted alongside a pop while full
        do_reset();
        bus.ev_ready = 1'b0;
        expect_ev(8'h16, 0, 0, 5'b00000);
        expect_ev(8'h1E, 0, 0, 5'b00000);
        expect_ev(8'h26, 0, 0, 5'b00000);
        expect_ev(8'h25, 0, 0, 5'b00000);
        expect_ev(8'h2E, 0, 0, 5'b00000);
        send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
        check("full_level", fifo_level, 4);
        bus.rx_data = 8'h2E; bus.rx_valid = 1'b1; bus.ev_ready = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0; bus.ev_ready = 1'b0;
        @(posedge clk); #1;
        check("pushpop_level", fifo_level, 4);
        check("pushpop_no_ovf", overflow, 0);
        bus.ev_ready = 1'b1;
        drain("drain_pushpop");

        // Reset mid-sequence with data queued and caps on
        bus.ev_ready = 1'b0;
        send(8'h1C); send(8'h58); send(8'hE0);
        check("pre_rst_caps", caps_led, 1);
        sb.delete();
        reset = 1'b1;
        #1;
        check("rst_mid_outputs",
              {22'h0, bus.ev_valid, bus.ev_code, bus.ev_ext, bus.ev_break, bus.ev_mods, bus.ev_upper},
              32'h0);
        check("rst_mid_status", {26'h0, caps_led, overflow, 1'b0, fifo_level}, 32'h0);
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        bus.ev_ready = 1'b1;
        @(posedge clk); #1;
        expect_ev(8'h1C, 0, 0, 5'b00000);
        send(8'h1C);
        drain("drain_after_rst");

        check("sb_left", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
